// File: rtl/multicycle_control_if.sv
// Control and handshake bundle between multicycle_control, the RV32I datapath and the memories.
// Defining INSTRET_COUNTER_EN adds the retired-instruction count.
interface multicycle_control_if;
  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned ALU_OP_W  = 2;
  localparam int unsigned WB_SEL_W  = 2;
  localparam int unsigned PC_SRC_W  = 2;
  localparam int unsigned INSTRET_W = 32;

  logic [INSTR_W-1:0]  instr;
  logic                branch_condition_match;
  logic                imem_req;
  logic                imem_ready;
  logic                ir_load;
  logic                dmem_req;
  logic                dmem_we;
  logic                dmem_ready;
  logic [ALU_OP_W-1:0] alu_operation;
  logic                alu_src1;
  logic                alu_src2;
  logic                is_rtype;
  logic                reg_write;
  logic [WB_SEL_W-1:0] wb_sel;
  logic                pc_write;
  logic [PC_SRC_W-1:0] pc_src;
  logic                illegal;
`ifdef INSTRET_COUNTER_EN
  logic [INSTRET_W-1:0] instret;
`endif

  modport master (
    input  instr, branch_condition_match, imem_ready, dmem_ready,
    output imem_req, ir_load, dmem_req, dmem_we, alu_operation, alu_src1, alu_src2,
           is_rtype, reg_write, wb_sel, pc_write, pc_src, illegal
`ifdef INSTRET_COUNTER_EN
    , output instret
`endif
  );

  modport slave (
    output instr, branch_condition_match, imem_ready, dmem_ready,
    input  imem_req, ir_load, dmem_req, dmem_we, alu_operation, alu_src1, alu_src2,
           is_rtype, reg_write, wb_sel, pc_write, pc_src, illegal
`ifdef INSTRET_COUNTER_EN
    , input instret
`endif
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I core: FETCH/DECODE/EXECUTE/MEM/WRITEBACK/TRAP.
// Optional INSTRET_COUNTER_EN macro adds a wrapping retired-instruction counter.
module multicycle_control #(
  parameter bit RESET_STATE_FETCH = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_NONE
  } iclass_t;

  localparam logic [1:0] ALU_NONE   = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_ADD    = 2'b10;
  localparam logic [1:0] ALU_ARITH  = 2'b11;

  state_t  state;
  iclass_t iclass;
  iclass_t decoded;
  logic [1:0] alu_op;
  logic       src1;
  logic       src2;
  logic       rtype;
  logic       unused_instr_hi;

  function automatic iclass_t decode_opcode(input logic [6:0] op);
    case (op)
      7'b0110011: return C_R;
      7'b0010011: return C_IALU;
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b1100011: return C_BRANCH;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      default:    return C_NONE;
    endcase
  endfunction

  assign decoded         = decode_opcode(bus.instr[6:0]);
  assign unused_instr_hi = ^bus.instr[31:7];

  // State and instruction-class registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RESET_STATE_FETCH ? S_FETCH : S_TRAP;
      iclass <= C_NONE;
    end else begin
      unique case (state)
        S_FETCH:     if (bus.imem_ready) state <= S_DECODE;
        S_DECODE: begin
          iclass <= decoded;
          state  <= (decoded == C_NONE) ? S_TRAP : S_EXECUTE;
        end
        S_EXECUTE: begin
          if (iclass == C_BRANCH)                           state <= S_FETCH;
          else if (iclass == C_LOAD || iclass == C_STORE)   state <= S_MEM;
          else                                              state <= S_WRITEBACK;
        end
        S_MEM:       if (bus.dmem_ready) state <= (iclass == C_STORE) ? S_FETCH : S_WRITEBACK;
        S_WRITEBACK: state <= S_FETCH;
        S_TRAP:      state <= S_TRAP;
        default:     state <= S_TRAP;
      endcase
    end
  end

  // ALU drive per class; held from EXECUTE through MEM and WRITEBACK
  always_comb begin
    alu_op = ALU_NONE;
    src1   = 1'b0;
    src2   = 1'b0;
    rtype  = 1'b0;
    unique case (iclass)
      C_R:                   begin alu_op = ALU_ARITH; rtype = 1'b1; end
      C_IALU:                begin alu_op = ALU_ARITH; src2  = 1'b1; end
      C_LOAD, C_STORE, C_JALR: begin alu_op = ALU_ADD; src2  = 1'b1; end
      C_AUIPC:               begin alu_op = ALU_ADD; src1 = 1'b1; src2 = 1'b1; end
      C_BRANCH:              alu_op = ALU_BRANCH;
      default:               ;
    endcase
  end

  always_comb begin
    bus.imem_req      = 1'b0;
    bus.ir_load       = 1'b0;
    bus.dmem_req      = 1'b0;
    bus.dmem_we       = 1'b0;
    bus.alu_operation = ALU_NONE;
    bus.alu_src1      = 1'b0;
    bus.alu_src2      = 1'b0;
    bus.is_rtype      = 1'b0;
    bus.reg_write     = 1'b0;
    bus.wb_sel        = 2'b00;
    bus.pc_write      = 1'b0;
    bus.pc_src        = 2'b00;
    bus.illegal       = 1'b0;
    if (!rst) begin
      if (state == S_EXECUTE || state == S_MEM || state == S_WRITEBACK) begin
        bus.alu_operation = alu_op;
        bus.alu_src1      = src1;
        bus.alu_src2      = src2;
        bus.is_rtype      = rtype;
      end
      unique case (state)
        S_FETCH: begin
          bus.imem_req = 1'b1;
          bus.ir_load  = bus.imem_ready;
        end
        S_EXECUTE: begin
          if (iclass == C_BRANCH) begin
            bus.pc_write = 1'b1;
            bus.pc_src   = bus.branch_condition_match ? 2'b01 : 2'b00;
          end
        end
        S_MEM: begin
          bus.dmem_req = 1'b1;
          bus.dmem_we  = (iclass == C_STORE);
          bus.pc_write = (iclass == C_STORE) && bus.dmem_ready;
        end
        S_WRITEBACK: begin
          bus.reg_write = 1'b1;
          bus.pc_write  = 1'b1;
          unique case (iclass)
            C_LOAD:        bus.wb_sel = 2'b01;
            C_JAL, C_JALR: bus.wb_sel = 2'b10;
            C_LUI:         bus.wb_sel = 2'b11;
            default:       bus.wb_sel = 2'b00;
          endcase
          unique case (iclass)
            C_JAL:   bus.pc_src = 2'b01;
            C_JALR:  bus.pc_src = 2'b10;
            default: bus.pc_src = 2'b00;
          endcase
        end
        S_TRAP:  bus.illegal = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef INSTRET_COUNTER_EN
  logic [31:0] instret_q;

  // One count per pc_write, i.e. per retired instruction
  always_ff @(posedge clk) begin
    if (rst)                                 instret_q <= 32'd0;
    else if (bus.pc_write && state != S_TRAP) instret_q <= instret_q + 32'd1;
  end

  assign bus.instret = rst ? 32'd0 : instret_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction cycle schedules expanded from the class tables,
// queued and compared against the DUT every cycle, plus literal pins on the schedules.
`timescale 1ns/1ps
module tb_multicycle_control;

  typedef struct packed {
    logic       imem_req;
    logic       ir_load;
    logic       dmem_req;
    logic       dmem_we;
    logic [1:0] alu_operation;
    logic       alu_src1;
    logic       alu_src2;
    logic       is_rtype;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       c;
    logic [31:0] instret;
  } exp_t;

  localparam int CL_ILL = -1, CL_R = 0, CL_I = 1, CL_LD = 2, CL_ST = 3, CL_BR = 4,
                 CL_JAL = 5, CL_JALR = 6, CL_LUI = 7, CL_AUIPC = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_if bus();
  multicycle_control #(.RESET_STATE_FETCH(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        expq[$];
  ctrl_t       sched[$];
  logic [31:0] retired = 32'd0;
  logic [6:0]  ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
    end
  endtask

  function automatic int cls_of(input logic [6:0] op);
    case (op)
      7'b0110011: return CL_R;
      7'b0010011: return CL_I;
      7'b0000011: return CL_LD;
      7'b0100011: return CL_ST;
      7'b1100011: return CL_BR;
      7'b1101111: return CL_JAL;
      7'b1100111: return CL_JALR;
      7'b0110111: return CL_LUI;
      7'b0010111: return CL_AUIPC;
      default:    return CL_ILL;
    endcase
  endfunction

  function automatic ctrl_t with_alu(input ctrl_t c, input int cls);
    case (cls)
      CL_R:                 begin c.alu_operation = 2'b11; c.is_rtype = 1'b1; end
      CL_I:                 begin c.alu_operation = 2'b11; c.alu_src2 = 1'b1; end
      CL_LD, CL_ST, CL_JALR: begin c.alu_operation = 2'b10; c.alu_src2 = 1'b1; end
      CL_AUIPC:             begin c.alu_operation = 2'b10; c.alu_src1 = 1'b1; c.alu_src2 = 1'b1; end
      CL_BR:                c.alu_operation = 2'b01;
      default:              ;
    endcase
    return c;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive one cycle of inputs and queue what the outputs must be in that cycle
  task automatic step(input logic r, input logic [31:0] ins, input logic ir, input logic dr,
                      input logic bm, input ctrl_t c);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    bus.instr = ins;
    bus.imem_ready = ir;
    bus.dmem_ready = dr;
    bus.branch_condition_match = bm;
    e.c = c;
    e.instret = r ? 32'd0 : retired;
    if (r) retired = 32'd0;
    else if (c.pc_write) retired = retired + 32'd1;
    expq.push_back(e);
    sched.push_back(c);
  endtask

  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic bm,
                           input int abort_mem, output int ncyc);
    ctrl_t c;
    int cls;
    cls = cls_of(ins[6:0]);
    sched.delete();
    for (int i = 0; i < fw; i++) begin
      c = '0; c.imem_req = 1'b1;
      step(1'b0, $urandom, 1'b0, rb(), rb(), c);
    end
    c = '0; c.imem_req = 1'b1; c.ir_load = 1'b1;
    step(1'b0, $urandom, 1'b1, rb(), rb(), c);
    step(1'b0, ins, rb(), rb(), rb(), '0);
    ncyc = sched.size();
    if (cls == CL_ILL) return;
    c = with_alu('0, cls);
    if (cls == CL_BR) begin
      c.pc_write = 1'b1;
      c.pc_src = bm ? 2'b01 : 2'b00;
      step(1'b0, ins, rb(), rb(), bm, c);
      ncyc = sched.size();
      return;
    end
    step(1'b0, ins, rb(), rb(), rb(), c);
    if (cls == CL_LD || cls == CL_ST) begin
      for (int i = 0; i < mw; i++) begin
        if (i == abort_mem) begin
          step(1'b1, ins, rb(), rb(), rb(), '0);
          ncyc = sched.size();
          return;
        end
        c = with_alu('0, cls); c.dmem_req = 1'b1; c.dmem_we = (cls == CL_ST);
        step(1'b0, ins, rb(), 1'b0, rb(), c);
      end
      c = with_alu('0, cls); c.dmem_req = 1'b1; c.dmem_we = (cls == CL_ST);
      c.pc_write = (cls == CL_ST);
      step(1'b0, ins, rb(), 1'b1, rb(), c);
      if (cls == CL_ST) begin
        ncyc = sched.size();
        return;
      end
    end
    c = with_alu('0, cls);
    c.reg_write = 1'b1;
    c.pc_write = 1'b1;
    c.wb_sel = (cls == CL_LD) ? 2'b01 : (cls == CL_JAL || cls == CL_JALR) ? 2'b10 :
               (cls == CL_LUI) ? 2'b11 : 2'b00;
    c.pc_src = (cls == CL_JAL) ? 2'b01 : (cls == CL_JALR) ? 2'b10 : 2'b00;
    step(1'b0, ins, rb(), rb(), rb(), c);
    ncyc = sched.size();
  endtask

  task automatic trap_then_reset(input int n);
    ctrl_t c;
    c = '0; c.illegal = 1'b1;
    for (int i = 0; i < n; i++) step(1'b0, $urandom, rb(), rb(), rb(), c);
    step(1'b1, $urandom, rb(), rb(), rb(), '0);
  endtask

  // Every-cycle comparison of the DUT against the queued expectation
  always @(negedge clk) begin
    exp_t  e;
    ctrl_t a;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a.imem_req      = bus.imem_req;
      a.ir_load       = bus.ir_load;
      a.dmem_req      = bus.dmem_req;
      a.dmem_we       = bus.dmem_we;
      a.alu_operation = bus.alu_operation;
      a.alu_src1      = bus.alu_src1;
      a.alu_src2      = bus.alu_src2;
      a.is_rtype      = bus.is_rtype;
      a.reg_write     = bus.reg_write;
      a.wb_sel        = bus.wb_sel;
      a.pc_write      = bus.pc_write;
      a.pc_src        = bus.pc_src;
      a.illegal       = bus.illegal;
      check("ctrl_outputs", 64'(a), 64'(e.c));
`ifdef INSTRET_COUNTER_EN
      check("instret", 64'(bus.instret), 64'(e.instret));
`endif
    end
  end

  initial begin
    int          nc;
    int          k;
    logic [31:0] r;
    logic [6:0]  op;
    rst = 1'b1;
    bus.instr = 32'd0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.branch_condition_match = 1'b0;
    step(1'b1, 32'd0, 1'b1, 1'b1, 1'b1, '0);
    step(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, '0);

    run_instr(32'h00500093, 0, 0, 1'b0, 99, nc);   // ADDI x1,x0,5
    check("addi_cycles", 64'(nc), 64'd4);
    check("addi_exec_alu", 64'({sched[2].alu_operation, sched[2].alu_src1, sched[2].alu_src2,
                                sched[2].is_rtype}), 64'(5'b11010));
    check("addi_wb", 64'({sched[3].reg_write, sched[3].wb_sel, sched[3].pc_src}), 64'(5'b10000));

    run_instr(32'h00208463, 0, 0, 1'b1, 99, nc);   // BEQ, taken
    check("beq_cycles", 64'(nc), 64'd3);
    check("beq_exec", 64'({sched[2].alu_operation, sched[2].pc_write, sched[2].pc_src}), 64'(5'b01101));
    check("beq_no_regwrite", 64'(sched[0].reg_write | sched[1].reg_write | sched[2].reg_write), 64'd0);

    run_instr(32'h0000A103, 0, 2, 1'b0, 99, nc);   // LW, two data wait states
    check("lw_cycles", 64'(nc), 64'd7);
    check("lw_mem_hold", 64'({sched[3].dmem_we, sched[5].dmem_we, sched[5].alu_operation,
                              sched[5].alu_src1, sched[5].alu_src2}), 64'(6'b001001));
    check("lw_wb_sel", 64'(sched[6].wb_sel), 64'd1);

    run_instr(32'h000080E7, 1, 0, 1'b0, 99, nc);   // JALR x1,0(x1), one fetch wait
    check("jalr_wb", 64'({sched[4].pc_src, sched[4].wb_sel, sched[4].reg_write, sched[4].pc_write}),
          64'(6'b101011));

    run_instr(32'h0000007F, 0, 0, 1'b0, 99, nc);   // illegal opcode
    check("illegal_cycles_to_trap", 64'(nc), 64'd2);
    trap_then_reset(10);

    run_instr(32'h0020A023, 0, 3, 1'b0, 1, nc);    // SW, reset during MEM
    check("sw_abort_reset_cycle", 64'(sched[nc-1]), 64'd0);
    check("sw_abort_count_cleared", 64'(retired), 64'd0);

    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 19);
      r = $urandom;
      op = (k == 0) ? 7'h7F : ops[$urandom_range(0, 8)];
      run_instr({r[31:7], op}, $urandom_range(0, 2), $urandom_range(0, 2), rb(),
                (k == 1) ? 0 : 99, nc);
      if (cls_of(op) == CL_ILL) trap_then_reset($urandom_range(1, 4));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32I core, sequencing FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Drives the `alu_operation`, `alu_src1`, `alu_src2` and `is_rtype` encodings consumed by the ALU control decoder and operand muxes.
- Consumes `branch_condition_match` from the branch unit and handshakes with instruction and data memories.
- Owns the PC-update, IR-load, register-write and writeback-select strobes; the datapath holds the PC, the IR and the register file.

Parameters:
- RESET_STATE_FETCH, 1, reset lands in FETCH (0 = reset lands in TRAP, used for bring-up only).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high
- instr  in  32  IR contents; valid from DECODE onward
- branch_condition_match  in  1  branch unit result
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch data valid this cycle
- ir_load  out  1  capture imem data into IR
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_ready  in  1  data access complete this cycle
- alu_operation  out  2  00 NO_ALU, 01 BRANCH_COMPARE, 10 ADD_OFFSET, 11 ARITHMETIC
- alu_src1  out  1  1 = PC, 0 = rs1
- alu_src2  out  1  1 = immediate, 0 = rs2
- is_rtype  out  1  opcode 0110011
- reg_write  out  1  register file write strobe
- wb_sel  out  2  00 ALU, 01 mem data, 10 PC+4, 11 immediate
- pc_write  out  1  PC update strobe
- pc_src  out  2  00 PC+4, 01 PC+imm, 10 ALU result with bit0 cleared
- illegal  out  1  sticky illegal-opcode flag

Behaviour:
- Reset values: state = FETCH. While rst is high, every output is forced to 0 (`alu_operation` = 00). The first `imem_req` appears in the cycle after rst deasserts. Reset in any state, mid-handshake included, abandons the instruction with no `pc_write` or `reg_write`.
- Outputs are combinational from the registered state, the registered instruction class and the inputs.
- FETCH:
  - `imem_req` = 1.
  - On `imem_ready`: `ir_load` = 1, next state DECODE. Otherwise stay.
  - `imem_ready` in the same cycle as `imem_req` is legal (zero wait states).
  - `imem_ready` and `dmem_ready` are ignored outside their request states.
- DECODE:
  - Register the class from `instr[6:0]`: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - Any other opcode goes to TRAP.
  - `alu_operation` = 00.
- EXECUTE, ALU drive by class:
  - R: 11 / src1 0 / src2 0 / `is_rtype` 1.
  - I-ALU: 11 / 0 / 1.
  - LOAD, STORE, JALR: 10 / 0 / 1.
  - AUIPC: 10 / 1 / 1.
  - BRANCH: 01 / 0 / 0.
  - JAL, LUI: 00.
- EXECUTE, next state:
  - BRANCH: `pc_write` = 1, `pc_src` = 01 if `branch_condition_match` else 00, next FETCH.
  - LOAD, STORE: next MEM.
  - All other classes: next WRITEBACK.
- MEM:
  - ALU outputs are held at their EXECUTE values, keeping the address stable.
  - `dmem_req` = 1, `dmem_we` = (class == STORE).
  - On `dmem_ready`: STORE asserts `pc_write` with `pc_src` = 00 and goes to FETCH; LOAD goes to WRITEBACK. Otherwise stay.
- WRITEBACK:
  - ALU outputs are held at their EXECUTE values.
  - `reg_write` = 1 (the register file ignores x0) and `pc_write` = 1, then next FETCH.
  - `wb_sel`: 01 for LOAD, 10 for JAL/JALR, 11 for LUI, 00 otherwise.
  - `pc_src`: 01 for JAL, 10 for JALR, 00 otherwise.
  - When rd == rs1 on JALR, both the PC and rd sample pre-edge values; no hazard.
- TRAP: `illegal` = 1, no requests and no strobes; held until rst.
- Minimum cycles per instruction: BRANCH 3; R/I/LUI/AUIPC/JAL/JALR/STORE 4; LOAD 5. Each wait state adds one cycle.
- Exactly one `pc_write` per retired instruction; `reg_write` and `pc_write` are never asserted outside the states above.

Optional Feature:
- Macro: INSTRET_COUNTER_EN.
- With the macro defined:
  - Adds output `instret` (32 bits), reset to 0.
  - Increments by 1 on every `pc_write` cycle and wraps 0xFFFFFFFF -> 0.
  - Not incremented in TRAP.
- Without the macro: the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- ADDI x1,x0,5 (0x00500093), `imem_ready` on first request -> 4 cycles; EXECUTE drives 11/0/1 with `is_rtype` 0; WRITEBACK drives `reg_write` 1, `wb_sel` 00, `pc_src` 00.
- BEQ (0x00208463) with `branch_condition_match` = 1 -> EXECUTE drives `alu_operation` 01, `pc_write` 1, `pc_src` 01; 3 cycles total, no `reg_write`.
- LW (0x0000A103), `dmem_ready` after 2 wait cycles -> MEM lasts 3 cycles with `dmem_we` 0 and ALU controls 10/0/1 held; WRITEBACK drives `wb_sel` 01; 7 cycles total.
- JALR x1,0(x1) (0x000080E7) -> WRITEBACK drives `pc_src` 10, `wb_sel` 10, `reg_write` 1 and `pc_write` 1 in the same cycle.
- Opcode 0x0000007F -> TRAP one cycle after DECODE; `illegal` = 1; no `imem_req` for 10 cycles; rst returns to FETCH with `illegal` = 0.
- rst asserted during a pending SW MEM state -> next cycle all outputs 0 with no `pc_write`; the cycle after rst deasserts drives `imem_req` 1. With INSTRET_COUNTER_EN, `instret` = 0.
